// File: rtl/tile_field_pkg.sv
// Shared definitions for the falling-tile playfield: cell codes, colours,
// FSM encoding and the LFSR step used for tile spawning.
package tile_field_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_A     = 2'b01,
    CELL_B     = 2'b10,
    CELL_C     = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [2:0] COLOUR_EMPTY = 3'b000;
  localparam logic [2:0] COLOUR_A     = 3'b010;
  localparam logic [2:0] COLOUR_B     = 3'b100;
  localparam logic [2:0] COLOUR_C     = 3'b011;

  function automatic logic [2:0] cellColour(input cell_t c);
    case (c)
      CELL_A:  return COLOUR_A;
      CELL_B:  return COLOUR_B;
      CELL_C:  return COLOUR_C;
      default: return COLOUR_EMPTY;
    endcase
  endfunction

  // Galois form: shift right, fold the mask back in when a one falls out.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/tile_field_engine_if.sv
// Pixel plot bus between the playfield engine and the VGA adapter.
interface tile_field_engine_if;
  logic [7:0] plotX;
  logic [6:0] plotY;
  logic [2:0] plotColour;
  logic       plotValid;
  logic       plotReady;

  modport master (output plotX, plotY, plotColour, plotValid, input plotReady);
  modport slave  (input plotX, plotY, plotColour, plotValid, output plotReady);
endinterface

// File: rtl/tile_tick_gen.sv
// Game tick counter: counts 0..TICK_CYCLES-1 while enabled and pulses on wrap.
module tile_tick_gen #(
  parameter int TICK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic wrap_o
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable_i) count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  assign wrap_o = enable_i && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/tile_field_engine.sv
// Falling-tile playfield: shifts the field down on each game tick, spawns a
// random tile in the top row and streams the whole field out pixel by pixel.
module tile_field_engine
  import tile_field_pkg::*;
#(
  parameter int          COLS        = 14,
  parameter int          ROWS        = 12,
  parameter int          CELL_PX     = 8,
  parameter int          TICK_CYCLES = 5000000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   clear_i,
  tile_field_engine_if.master    plot,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [2*COLS-1:0]      bottom_row_o,
  output logic                   bottom_valid_o,
  output logic                   overrun_o
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [PW-1:0] PX_LAST  = PW'(CELL_PX - 1);

  state_t                           state_q;
  logic [15:0]                      lfsr_q;
  logic [ROWS-1:0][COLS-1:0][1:0]   field_q;
  logic [COLS-1:0][1:0]             bottomRow_q;
  logic                             tickPend_q, clrPend_q, overrun_q;
  logic                             bottomValid_q, frameDone_q;
  logic [RW-1:0]                    row_q;
  logic [CW-1:0]                    col_q;
  logic [PW-1:0]                    dy_q, dx_q;
  logic [7:0]                       plotX_q;
  logic [6:0]                       plotY_q;
  logic [2:0]                       plotColour_q;
  logic                             plotValid_q;

  logic                             wrap;
  logic [RW-1:0]                    rowN;
  logic [CW-1:0]                    colN;
  logic [PW-1:0]                    dyN, dxN;
  logic                             lastPix;
  logic [CW-1:0]                    spawnCol;
  logic [1:0]                       spawnCell;
  logic [COLS-1:0][1:0]             spawnRow;

  tile_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable_i),
    .wrap_o   (wrap)
  );

  // Raster order: dx fastest, then dy within the cell, then column, then row.
  always_comb begin
    rowN    = row_q;
    colN    = col_q;
    dyN     = dy_q;
    dxN     = dx_q;
    lastPix = 1'b0;
    if (dx_q != PX_LAST) dxN = dx_q + PW'(1);
    else begin
      dxN = '0;
      if (dy_q != PX_LAST) dyN = dy_q + PW'(1);
      else begin
        dyN = '0;
        if (col_q != COL_LAST) colN = col_q + CW'(1);
        else begin
          colN = '0;
          if (row_q != ROW_LAST) rowN = row_q + RW'(1);
          else                   lastPix = 1'b1;
        end
      end
    end
  end

  // A zero colour code would spawn nothing, so it is promoted to CELL_A.
  always_comb begin
    spawnCol  = CW'(lfsr_q[15:8] % 8'(COLS));
    spawnCell = (lfsr_q[1:0] == 2'b00) ? CELL_A : lfsr_q[1:0];
    spawnRow  = '0;
    spawnRow[spawnCol] = spawnCell;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= SEED;
      field_q       <= '0;
      bottomRow_q   <= '0;
      tickPend_q    <= 1'b0;
      clrPend_q     <= 1'b0;
      overrun_q     <= 1'b0;
      bottomValid_q <= 1'b0;
      frameDone_q   <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      dy_q          <= '0;
      dx_q          <= '0;
      plotX_q       <= '0;
      plotY_q       <= '0;
      plotColour_q  <= '0;
      plotValid_q   <= 1'b0;
    end else begin
      lfsr_q        <= lfsrNext(lfsr_q);
      bottomValid_q <= 1'b0;
      frameDone_q   <= 1'b0;
      tickPend_q    <= tickPend_q | wrap;
      if (wrap && tickPend_q) overrun_q <= 1'b1;
      if (clear_i) clrPend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (clrPend_q || clear_i) begin
            field_q      <= '0;
            overrun_q    <= 1'b0;
            tickPend_q   <= 1'b0;
            clrPend_q    <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            dy_q         <= '0;
            dx_q         <= '0;
            plotX_q      <= '0;
            plotY_q      <= '0;
            plotColour_q <= COLOUR_EMPTY;
            plotValid_q  <= 1'b1;
            state_q      <= ST_DRAW;
          end else if (tickPend_q || wrap) begin
            tickPend_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          for (int r = ROWS - 1; r > 0; r--) field_q[r] <= field_q[r-1];
          field_q[0]    <= spawnRow;
          bottomRow_q   <= field_q[ROWS-1];
          bottomValid_q <= 1'b1;
          tickPend_q    <= wrap;
          row_q         <= '0;
          col_q         <= '0;
          dy_q          <= '0;
          dx_q          <= '0;
          plotX_q       <= '0;
          plotY_q       <= '0;
          plotColour_q  <= cellColour(cell_t'(spawnRow[0]));
          plotValid_q   <= 1'b1;
          state_q       <= ST_DRAW;
        end

        // The field is frozen here, so it doubles as the frame snapshot.
        ST_DRAW: begin
          if (plotValid_q && plot.plotReady) begin
            if (lastPix) begin
              plotValid_q <= 1'b0;
              frameDone_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              row_q        <= rowN;
              col_q        <= colN;
              dy_q         <= dyN;
              dx_q         <= dxN;
              plotX_q      <= 8'(colN) * 8'(CELL_PX) + 8'(dxN);
              plotY_q      <= 7'(rowN) * 7'(CELL_PX) + 7'(dyN);
              plotColour_q <= cellColour(cell_t'(field_q[rowN][colN]));
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign plot.plotX      = plotX_q;
  assign plot.plotY      = plotY_q;
  assign plot.plotColour = plotColour_q;
  assign plot.plotValid  = plotValid_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign frame_done_o    = frameDone_q;
  assign bottom_row_o    = bottomRow_q;
  assign bottom_valid_o  = bottomValid_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_tile_field_engine.sv
// Scoreboard bench for tile_field_engine on a 4x3 field of 2-pixel cells.
module tb_tile_field_engine;

  localparam int          COLS  = 4;
  localparam int          ROWS  = 3;
  localparam int          PX    = 2;
  localparam int          TICKS = 20;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       busy, frameDone, bottomValid, overrun;
  logic [7:0] bottomRow;

  tile_field_engine_if plotBus ();

  tile_field_engine #(
    .COLS(COLS), .ROWS(ROWS), .CELL_PX(PX), .TICK_CYCLES(TICKS), .SEED(SEED)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .plot           (plotBus.master),
    .busy_o         (busy),
    .frame_done_o   (frameDone),
    .bottom_row_o   (bottomRow),
    .bottom_valid_o (bottomValid),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  pixel_t                   expQ[$];
  logic [15:0]              mLfsr, mLfsrPrev;
  logic [2:0][3:0][1:0]     mField;
  int                       cyc;
  int                       nShiftsTotal = 0, nFramesDone = 0, nClearFrames = 0;
  int                       clearsIssued = 0;
  int                       shiftsSinceReset = 0, pixIdx = 0;
  bit                       inFrame = 0, holdPend = 0;
  pixel_t                   holdPix;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic clr, input logic rdy);
    @(negedge clk);
    rst_n = r;
    enable = en;
    clear = clr;
    plotBus.plotReady = rdy;
  endtask

  function automatic logic [2:0] colourOf(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      2'b11:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int counterOf(input int which);
    case (which)
      0:       return nShiftsTotal;
      1:       return nFramesDone;
      2:       return nClearFrames;
      default: return int'(plotBus.plotValid);
    endcase
  endfunction

  task automatic waitFor(input string name, input int which, input int target, input int budget);
    int n = 0;
    while (counterOf(which) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(counterOf(which) >= target), 64'd1);
  endtask

  // Spec-level LFSR; mLfsrPrev holds the value seen during the previous cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLfsr     <= SEED;
      mLfsrPrev <= SEED;
      cyc       <= 0;
    end else begin
      mLfsrPrev <= mLfsr;
      mLfsr     <= mLfsr[0] ? ((mLfsr >> 1) ^ 16'hB400) : (mLfsr >> 1);
      cyc       <= cyc + 1;
    end
  end

  // Monitor: updates the field model, queues each frame, checks every accepted pixel.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      inFrame = 0;
      holdPend = 0;
      shiftsSinceReset = 0;
      mField = '0;
    end else begin
      if (bottomValid) begin
        int spawnCol;
        logic [1:0] spawnVal;
        nShiftsTotal++;
        shiftsSinceReset++;
        if (shiftsSinceReset == 1) checkOutput("first tick latency", 64'(cyc), 64'd21);
        checkOutput("bottom_row", 64'(bottomRow), 64'(mField[2]));
        spawnCol = int'(mLfsrPrev[15:8]) % COLS;
        spawnVal = (mLfsrPrev[1:0] == 2'b00) ? 2'b01 : mLfsrPrev[1:0];
        mField[2] = mField[1];
        mField[1] = mField[0];
        mField[0] = '0;
        mField[0][spawnCol] = spawnVal;
        checkOutput("field after shift", 64'(dut.field_q), 64'(mField));
      end
      if (plotBus.plotValid && !inFrame) begin
        if (!bottomValid) begin
          if (clearsIssued > nClearFrames) begin
            mField = '0;
            nClearFrames++;
            checkOutput("overrun cleared at redraw", 64'(overrun), 64'd0);
          end else begin
            checkOutput("frame start cause", 64'd0, 64'd1);
          end
        end
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            for (int dy = 0; dy < PX; dy++)
              for (int dx = 0; dx < PX; dx++)
                expQ.push_back('{x: 8'(c*PX + dx), y: 7'(r*PX + dy), colour: colourOf(mField[r][c])});
        inFrame = 1;
        pixIdx = 0;
      end
      if (holdPend)
        checkOutput("stall hold", {1'b1, plotBus.plotValid, plotBus.plotX, plotBus.plotY, plotBus.plotColour},
                    {1'b1, 1'b1, holdPix});
      holdPend = 0;
      if (plotBus.plotValid && inFrame) begin
        if (plotBus.plotReady) begin
          if (expQ.size() == 0) checkOutput("pixel beyond frame", 64'd0, 64'd1);
          else begin
            pixel_t e;
            e = expQ.pop_front();
            checkOutput("pixel", {plotBus.plotX, plotBus.plotY, plotBus.plotColour}, e);
            if (pixIdx == 7) checkOutput("pixel 7 position", {plotBus.plotX, plotBus.plotY}, {8'd3, 7'd1});
          end
          pixIdx++;
        end else begin
          holdPend = 1;
          holdPix = {plotBus.plotX, plotBus.plotY, plotBus.plotColour};
        end
      end
      if (frameDone) begin
        checkOutput("frame length", 64'(pixIdx), 64'd48);
        checkOutput("frame drained", 64'(expQ.size()), 64'd0);
        inFrame = 0;
        nFramesDone++;
      end
    end
  end

  initial begin
    logic [3:0] readyPat;
    int framesBefore;
    readyPat = 4'b1001;
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    plotBus.plotReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs",
                {plotBus.plotX, plotBus.plotY, plotBus.plotColour, plotBus.plotValid,
                 busy, frameDone, bottomRow, bottomValid, overrun}, 64'd0);
    checkOutput("reset lfsr", 64'(dut.lfsr_q), 64'(SEED));

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    waitFor("four ticks", 0, 4, 800);

    for (int k = 0; k < 240; k++) begin
      @(posedge clk);
      #1 plotBus.plotReady = readyPat[k % 4];
    end
    @(posedge clk);
    #1 plotBus.plotReady = 1'b1;
    framesBefore = nFramesDone;
    waitFor("frame after toggling", 1, framesBefore + 1, 300);

    waitFor("draw before reset", 3, 1, 300);
    repeat (5) @(negedge clk);
    checkOutput("valid before reset", 64'(plotBus.plotValid), 64'd1);
    rst_n = 1'b0;
    plotBus.plotReady = 1'b0;
    #1 checkOutput("valid drops in reset", 64'(plotBus.plotValid), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("field zero in reset", 64'(dut.field_q), 64'd0);
    checkOutput("lfsr seed in reset", 64'(dut.lfsr_q), 64'(SEED));

    framesBefore = nShiftsTotal;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitFor("stalled frame starts", 0, framesBefore + 1, 100);
    checkOutput("no overrun yet", 64'(overrun), 64'd0);
    repeat (45) @(negedge clk);
    checkOutput("overrun after lost tick", 64'(overrun), 64'd1);
    checkOutput("busy while stalled", 64'(busy), 64'd1);

    clearsIssued++;
    rst_n = 1'b1;
    enable = 1'b0;
    clear = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    framesBefore = nFramesDone;
    waitFor("clear redraw starts", 2, 1, 200);
    waitFor("clear redraw done", 1, framesBefore + 2, 200);
    repeat (3) @(negedge clk);
    checkOutput("idle after redraw", {busy, overrun}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
